// File: rtl/pad_frame_seq.sv
// Frames a vector stream into FRAME_LEN-vector frames with a registered
// output stage, a last marker and at least GAP_CYCLES dead cycles between frames.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   data_i/valid_i/ready_o  upstream vector handshake
//   data_o/valid_o/last_o/ready_i  downstream handshake, last_o on final vector
//   frame_start_o         pulse when a frame's first vector is accepted
//   frame_cnt_o           completed frame count (wraps)
module pad_frame_seq #(
  parameter  int BW         = 8,
  parameter  int VECTOR_LEN = 13,
  parameter  int FRAME_LEN  = 50,
  parameter  int GAP_CYCLES = 2,
  localparam int VECTOR_BW  = BW * VECTOR_LEN
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [VECTOR_BW-1:0] data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic signed [VECTOR_BW-1:0] data_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic                        frame_start_o,
  output logic [15:0]                 frame_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    GAP
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] vec_cnt;
  logic [15:0] vec_cnt_nxt;
  logic [7:0]  gap_cnt;
  logic [7:0]  gap_cnt_nxt;

  logic gap_done;
  logic out_free;
  logic accept;
  logic xfer;
  logic last_in;

  assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);
  assign out_free = !valid_o || ready_i;
  assign ready_o  = !rst_i && out_free &&
                    ((state == IDLE) || (state == STREAM) || gap_done);
  assign accept   = valid_i && ready_o;
  assign xfer     = valid_o && ready_i;
  assign last_in  = (state == STREAM) && (vec_cnt == LAST_IDX);

  always_comb begin
    state_nxt     = state;
    vec_cnt_nxt   = vec_cnt;
    gap_cnt_nxt   = gap_cnt;
    frame_start_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = STREAM;
          vec_cnt_nxt   = 16'd1;
          frame_start_o = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          if (last_in) begin
            vec_cnt_nxt = 16'd0;
            state_nxt   = DRAIN;
          end else begin
            vec_cnt_nxt = vec_cnt + 16'd1;
          end
        end
      end
      DRAIN: begin
        // only the last vector can be on the output here
        if (xfer) begin
          gap_cnt_nxt = 8'd0;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + 8'd1;
        if (gap_done) begin
          if (accept) begin
            state_nxt     = STREAM;
            vec_cnt_nxt   = 16'd1;
            frame_start_o = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      vec_cnt     <= 16'd0;
      gap_cnt     <= 8'd0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      frame_cnt_o <= 16'd0;
    end else begin
      state   <= state_nxt;
      vec_cnt <= vec_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      // accept implies the output slot is free or emptying this cycle
      if (accept) begin
        data_o  <= data_i;
        valid_o <= 1'b1;
        last_o  <= last_in;
      end else if (xfer) begin
        data_o  <= '0;
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
      if ((state == DRAIN) && xfer) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pad_frame_seq.sv
// Randomized bench for pad_frame_seq against a frame-level reference model.
// FRAME_LEN=4, GAP_CYCLES=2.
module tb_pad_frame_seq;

  localparam int BW  = 8;
  localparam int VL  = 13;
  localparam int VW  = BW * VL;
  localparam int FL  = 4;
  localparam int GAP = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic signed [VW-1:0] data_i = '0;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic signed [VW-1:0] data_o;
  logic                 valid_o;
  logic                 last_o;
  logic                 ready_i = 1'b1;
  logic                 frame_start_o;
  logic [15:0]          frame_cnt_o;

  pad_frame_seq #(
    .BW(BW),
    .VECTOR_LEN(VL),
    .FRAME_LEN(FL),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .valid_o(valid_o),
    .last_o(last_o),
    .ready_i(ready_i),
    .frame_start_o(frame_start_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame position, output slot, gap distance
  logic signed [VW-1:0] m_data = '0;
  logic                 m_valid = 1'b0;
  logic                 m_last = 1'b0;
  logic [15:0]          m_fcnt = 16'd0;
  int                   m_k = 0;
  bit                   m_wait_last = 1'b0;
  int                   m_since = GAP;

  always @(negedge clk_i) begin
    bit exp_rdy;
    bit acc;
    bit xfer;
    if (rst_i) begin
      chk("ready_rst", 128'(ready_o), 128'(1'b0));
      chk("fstart_rst", 128'(frame_start_o), 128'(1'b0));
      m_valid     = 1'b0;
      m_data      = '0;
      m_last      = 1'b0;
      m_fcnt      = 16'd0;
      m_k         = 0;
      m_wait_last = 1'b0;
      m_since     = GAP;
    end else begin
      exp_rdy = !m_wait_last && (m_since >= GAP) && (!m_valid || ready_i);
      chk("ready", 128'(ready_o), 128'(exp_rdy));
      chk("valid", 128'(valid_o), 128'(m_valid));
      chk("data", 128'(data_o), 128'(m_data));
      chk("last", 128'(last_o), 128'(m_last));
      chk("fcnt", 128'(frame_cnt_o), 128'(m_fcnt));
      acc  = valid_i && exp_rdy;
      xfer = m_valid && ready_i;
      chk("fstart", 128'(frame_start_o), 128'(acc && (m_k == 0)));
      if (m_since < 1000) m_since++;
      if (xfer && m_last) begin
        m_fcnt      = m_fcnt + 16'd1;
        m_wait_last = 1'b0;
        m_since     = 1;
      end
      if (xfer) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_data  = data_i;
        m_last  = (m_k == FL - 1);
        if (m_k == FL - 1) begin
          m_wait_last = 1'b1;
          m_k         = 0;
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rnd_rdy) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic signed [VW-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    valid_i = 1'b1;
    data_i  = d;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      acc = ready_o;
      tick();
      n++;
    end
    if (!acc) chk("push_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic signed [VW-1:0] rnd_vec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[VW-1:0];
  endfunction

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    idle(2);

    // continuous stream of two frames
    for (int i = 1; i <= 8; i++) push(VW'(i));
    idle(6);

    // stall while the second vector sits on the output
    push(VW'(11));
    push(VW'(12));
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = VW'(13);
    repeat (3) tick();
    ready_i = 1'b1;
    push(VW'(13));
    push(VW'(14));
    idle(6);

    // stall on the last vector of a frame
    for (int i = 21; i <= 24; i++) push(VW'(i));
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = VW'(25);
    repeat (3) tick();
    ready_i = 1'b1;
    for (int i = 25; i <= 28; i++) push(VW'(i));
    idle(6);

    // upstream gaps inside a frame
    for (int i = 41; i <= 44; i++) begin
      push(VW'(i));
      idle(5);
    end

    // reset in the middle of a frame
    push(VW'(51));
    push(VW'(52));
    valid_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 61; i <= 64; i++) push(VW'(i));
    idle(6);

    // randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push(rnd_vec());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    rnd_rdy = 1'b0;
    ready_i = 1'b1;
    idle(4);

    // frame counter wrap
    force dut.frame_cnt_o = 16'hFFFF;
    m_fcnt = 16'hFFFF;
    tick();
    release dut.frame_cnt_o;
    idle(2);
    for (int i = 71; i <= 74; i++) push(VW'(i));
    idle(8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pad_frame_seq.md
PAD_FRAME_SEQ -- requirements
Module: pad_frame_seq

Interface
REQ-001 The block SHALL have parameter BW, default 8, meaning bits per vector element.
REQ-002 The block SHALL have parameter VECTOR_LEN, default 13, meaning elements per vector (VECTOR_BW = BW*VECTOR_LEN, local).
REQ-003 The block SHALL have parameter FRAME_LEN, default 50, meaning vectors per frame (legal range 2..65535).
REQ-004 The block SHALL have parameter GAP_CYCLES, default 2, meaning minimum output dead cycles between frames (legal range 1..255).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk_i, input, 1 bit, the clock (all logic on rising edge).
REQ-007 The block SHALL have port rst_i, input, 1 bit, the synchronous active-high reset.
REQ-008 The block SHALL have port data_i, input, VECTOR_BW bits, signed upstream vector.
REQ-009 The block SHALL have port valid_i, input, 1 bit, upstream valid.
REQ-010 The block SHALL have port ready_o, output, 1 bit, upstream ready.
REQ-011 The block SHALL have port data_o, output, VECTOR_BW bits, signed vector to the zero_pad stage.
REQ-012 The block SHALL have port valid_o, output, 1 bit, downstream valid.
REQ-013 The block SHALL have port last_o, output, 1 bit, marks the final vector of a frame.
REQ-014 The block SHALL have port ready_i, input, 1 bit, downstream ready.
REQ-015 The block SHALL have port frame_start_o, output, 1 bit, one-cycle pulse when a frame's first vector is accepted.
REQ-016 The block SHALL have port frame_cnt_o, output, 16 bits, count of completed frames.

Function
REQ-017 Transfers: upstream on valid_i & ready_o; downstream on valid_o & ready_i.
REQ-018 Output SHALL be a single registered stage: an accepted vector appears on data_o/valid_o the next cycle, giving 1-cycle latency.
REQ-019 data_o, valid_o and last_o SHALL hold stable while valid_o=1 & ready_i=0.
REQ-020 data_o SHALL be all-zero whenever valid_o=0.
REQ-021 The FSM SHALL have states IDLE, STREAM, DRAIN and GAP.
REQ-022 ready_o SHALL be (IDLE or STREAM or (GAP and gap_cnt==GAP_CYCLES-1)) and (!valid_o or ready_i), combinationally.
REQ-023 IDLE SHALL go to STREAM on an accept; frame_start_o=1 that cycle (combinational); vec_cnt <= 1.
REQ-024 STREAM SHALL increment vec_cnt on each accept; the accept with vec_cnt==FRAME_LEN-1 loads last_o=1, clears vec_cnt and goes to DRAIN.
REQ-025 DRAIN SHALL hold ready_o=0; on downstream transfer of the last vector: valid_o<=0, last_o<=0, gap_cnt<=0, frame_cnt_o<=frame_cnt_o+1 (wraps 0xFFFF->0), state to GAP.
REQ-026 GAP SHALL increment gap_cnt each cycle; at gap_cnt==GAP_CYCLES-1 it goes to IDLE, or to STREAM if an accept occurs that same cycle (frame_start_o=1, vec_cnt<=1).
REQ-027 Between the last vector of one frame and the first of the next, valid_o SHALL be 0 for at least GAP_CYCLES cycles, and for exactly GAP_CYCLES when upstream is continuously valid and ready_i=1.
REQ-028 Within a frame, back-to-back vectors SHALL sustain 1 vector/cycle when ready_i=1.
REQ-029 Upstream idle mid-frame (valid_i=0 in STREAM) SHALL leave the state unchanged; valid_o drops after the output drains; no timeout.
REQ-030 last_o SHALL be 1 only with the FRAME_LEN-th vector of a frame.
REQ-031 gap_cnt width SHALL be 8 bits; vec_cnt width SHALL be 16 bits.

Reset
REQ-032 While rst_i=1 at a clock edge, the block SHALL go to IDLE with vec_cnt=0, gap_cnt=0, valid_o=0, last_o=0, data_o=0, frame_cnt_o=0.
REQ-033 During reset frame_start_o SHALL be 0 and ready_o SHALL be 0 (gated by rst_i).
REQ-034 Reset mid-frame or mid-gap SHALL abandon the partial frame; the next accepted vector after reset SHALL start a new frame.

Verification (FRAME_LEN=4, GAP_CYCLES=2, ready_i=1 unless stated)
REQ-035 Continuous valid_i, vectors 1..8 -> data_o 1,2,3,4 on consecutive cycles, last_o with 4, valid_o low exactly 2 cycles, then 5..8 with last_o on 8, frame_cnt_o 1 then 2, frame_start_o pulses on accept of 1 and 5.
REQ-036 ready_i=0 for 3 cycles while vector 2 on output -> data_o=2 held 3 cycles, ready_o=0, no vector lost or duplicated.
REQ-037 ready_i=0 while last vector 4 on output -> DRAIN held, ready_o=0, gap starts only after transfer of 4.
REQ-038 valid_i gaps of 5 cycles between vectors inside a frame -> no extra last_o, frame completes on the 4th vector.
REQ-039 rst_i=1 for 1 cycle after vector 2 accepted -> all outputs zero, frame_cnt_o=0; next 4 vectors form a full frame with last_o on the 4th.
REQ-040 Preload frame_cnt_o to 0xFFFF via 65535 frames (or force) -> next completed frame gives 0x0000.
